// File: rtl/mda_vram_arbiter.sv
// mda_vram_arbiter
// Shares the single-port MDA video SRAM between the sequencer's pixel fetch
// path and ISA CPU memory cycles in the B0000-B7FFF window. Pixel fetch always
// has priority. ISA accesses run only in sequencer-granted slots, and the ISA
// bus is held off with isa_rdy until the access completes.
//
// Optional feature: define VRAM_TIMEOUT_EN to add a watchdog. After TIMEOUT_MAX
// cycles in WAIT/ACC1/ACC2 the access is abandoned. A read then returns 8'hFF
// and a write is dropped.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   isa_addr/din            ISA address and write data
//   isa_memr_l/memw_l       asynchronous active-low ISA memory strobes
//   isa_dout                registered ISA read data
//   isa_dir                 1 = drive the ISA data bus (combinational)
//   isa_rdy                 0 = insert ISA wait states
//   pixel_addr/pixel_read   sequencer pixel fetch; pixel_read=1 owns the SRAM
//   isa_op_enable           sequencer slot open for an ISA access
//   ram_a/ram_d/ram_wdata   SRAM address, read data, write data
//   ram_we_l                SRAM write enable, active-low
module mda_vram_arbiter #(
  parameter int unsigned VRAM_AW     = 12,
  parameter logic [4:0]  WIN_BASE    = 5'b10110,
  parameter int unsigned TIMEOUT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] isa_addr,
  input  logic        isa_memr_l,
  input  logic        isa_memw_l,
  input  logic [7:0]  isa_din,
  output logic [7:0]  isa_dout,
  output logic        isa_dir,
  output logic        isa_rdy,
  input  logic [18:0] pixel_addr,
  input  logic        pixel_read,
  input  logic        isa_op_enable,
  output logic [18:0] ram_a,
  input  logic [7:0]  ram_d,
  output logic [7:0]  ram_wdata,
  output logic        ram_we_l
);

  typedef enum logic [2:0] {StIdle, StWait, StAcc1, StAcc2, StDone} state_e;

  state_e               state_q, state_d;
  logic [VRAM_AW-1:0]   lat_addr_q, lat_addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic [7:0]           dout_q, dout_d;
  logic                 is_wr_q, is_wr_d;
  logic                 we;

  // [0],[1] form the 2-FF synchronizer; [2] is the previous synced value
  // used only for falling-edge detection.
  logic [2:0] memr_s, memw_s;
  logic       memr_fall, memw_fall, win_cs, start;

  // Offset bits above VRAM_AW are ignored: the 4 KB VRAM mirrors across the window.
  logic unused_addr;
  assign unused_addr = ^isa_addr[14:VRAM_AW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memr_s <= 3'b111;
      memw_s <= 3'b111;
    end else begin
      memr_s <= {memr_s[1:0], isa_memr_l};
      memw_s <= {memw_s[1:0], isa_memw_l};
    end
  end

  assign memr_fall = memr_s[2] & ~memr_s[1];
  assign memw_fall = memw_s[2] & ~memw_s[1];
  assign win_cs    = (isa_addr[19:15] == WIN_BASE);
  assign start     = win_cs & (memr_fall | memw_fall);

  // Bus direction follows the raw strobe so the data bus turns around immediately.
  assign isa_dir = win_cs & ~isa_memr_l;

`ifdef VRAM_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_MAX - 1);
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    is_wr_d    = is_wr_q;
    we         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          lat_addr_d = isa_addr[VRAM_AW-1:0];
          wdata_d    = isa_din;
          is_wr_d    = memw_fall;  // simultaneous strobes: write wins
          state_d    = StWait;
        end
      end
      StWait: begin
        if (isa_op_enable && !pixel_read) state_d = StAcc1;
      end
      StAcc1: begin
        state_d = pixel_read ? StWait : StAcc2;
      end
      StAcc2: begin
        if (pixel_read) begin
          state_d = StWait;
        end else begin
          if (is_wr_q) we = 1'b1;
          else         dout_d = ram_d;
          state_d = StDone;
        end
      end
      StDone: begin
        // Hold until the CPU releases the strobe so one strobe never makes two accesses.
        if (memr_s[1] && memw_s[1]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef VRAM_TIMEOUT_EN
    cnt_d = cnt_q;
    if (state_q == StWait || state_q == StAcc1 || state_q == StAcc2) begin
      if (cnt_q == TimeoutLast) begin
        state_d = StDone;
        we      = 1'b0;
        dout_d  = is_wr_q ? dout_q : 8'hFF;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (state_d == StIdle) cnt_d = 8'd0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lat_addr_q <= '0;
      wdata_q    <= 8'd0;
      dout_q     <= 8'd0;
      is_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      is_wr_q    <= is_wr_d;
    end
  end

  assign ram_a     = pixel_read ? pixel_addr : {{(19 - VRAM_AW){1'b0}}, lat_addr_q};
  assign ram_wdata = wdata_q;
  assign ram_we_l  = ~we;
  assign isa_dout  = dout_q;
  assign isa_rdy   = (state_q == StIdle) || (state_q == StDone);

endmodule

// File: tb/tb_mda_vram_arbiter.sv
module tb_mda_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] isa_addr;
  logic        isa_memr_l, isa_memw_l;
  logic [7:0]  isa_din, isa_dout;
  logic        isa_dir, isa_rdy;
  logic [18:0] pixel_addr;
  logic        pixel_read, isa_op_enable;
  logic [18:0] ram_a;
  logic [7:0]  ram_d, ram_wdata;
  logic        ram_we_l;

  logic [7:0]  mem [0:4095];
  logic [26:0] wr_q [$];  // expected {ram_a, ram_wdata} per write pulse
  logic [7:0]  rd_q [$];  // expected isa_dout per completed read
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulses = 0;
  logic        pix_apply = 1'b0;
  logic [18:0] pix_addr_next;

  always #5 clk = ~clk;

  assign ram_d = mem[ram_a[11:0]];

  mda_vram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .isa_addr     (isa_addr),
    .isa_memr_l   (isa_memr_l),
    .isa_memw_l   (isa_memw_l),
    .isa_din      (isa_din),
    .isa_dout     (isa_dout),
    .isa_dir      (isa_dir),
    .isa_rdy      (isa_rdy),
    .pixel_addr   (pixel_addr),
    .pixel_read   (pixel_read),
    .isa_op_enable(isa_op_enable),
    .ram_a        (ram_a),
    .ram_d        (ram_d),
    .ram_wdata    (ram_wdata),
    .ram_we_l     (ram_we_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: optional pixel takeover 1 ns after the edge, sample 2 ns after.
  // Any write pulse is scored against the expected-write queue and applied to the RAM model.
  task automatic cyc();
    logic [26:0] e;
    @(posedge clk);
    #1;
    if (pix_apply) begin
      pixel_read = 1'b1;
      pixel_addr = pix_addr_next;
      pix_apply  = 1'b0;
    end
    #1;
    if (ram_we_l === 1'b0) begin
      pulses++;
      check("we_expected", {31'd0, wr_q.size() != 0}, 32'd1);
      if (wr_q.size() != 0) begin
        e = wr_q.pop_front();
        check("wr_addr", {13'd0, ram_a}, {13'd0, e[26:8]});
        check("wr_data", {24'd0, ram_wdata}, {24'd0, e[7:0]});
      end
      mem[ram_a[11:0]] = ram_wdata;
    end
  endtask

  task automatic run_until_rdy(input int max, output int n);
    n = 0;
    while (isa_rdy !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
    check("rdy_timeout", {31'd0, isa_rdy}, 32'd1);
  endtask

  task automatic start_access(input logic wr, input logic [19:0] a, input logic [7:0] d);
    isa_addr = a;
    isa_din  = d;
    if (wr) isa_memw_l = 1'b0;
    else    isa_memr_l = 1'b0;
  endtask

  task automatic release_strobes();
    isa_memr_l = 1'b1;
    isa_memw_l = 1'b1;
    repeat (4) cyc();
  endtask

  initial begin
    int n, p0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    reset = 1'b1; isa_addr = 20'h0; isa_memr_l = 1'b1; isa_memw_l = 1'b1;
    isa_din = 8'h0; pixel_addr = 19'h0; pixel_read = 1'b0; isa_op_enable = 1'b0;
    pix_addr_next = 19'h0;
    repeat (2) cyc();
    check("rst_rdy", {31'd0, isa_rdy}, 32'd1);
    check("rst_dout", {24'd0, isa_dout}, 32'd0);
    check("rst_we_l", {31'd0, ram_we_l}, 32'd1);
    check("rst_wdata", {24'd0, ram_wdata}, 32'd0);
    check("rst_ram_a", {13'd0, ram_a}, 32'd0);
    reset = 1'b0;
    repeat (2) cyc();

    // Test 1: write B0010 <- 5A, slot opens 4 clk after isa_rdy falls.
    p0 = pulses;
    wr_q.push_back({19'h00010, 8'h5A});
    start_access(1'b1, 20'hB0010, 8'h5A);
    cyc(); cyc();
    check("t1_rdy_2clk", {31'd0, isa_rdy}, 32'd1);
    cyc();
    check("t1_rdy_3clk", {31'd0, isa_rdy}, 32'd0);
    repeat (4) cyc();
    check("t1_rdy_wait", {31'd0, isa_rdy}, 32'd0);
    check("t1_no_early_we", pulses - p0, 32'd0);
    isa_op_enable = 1'b1;
    run_until_rdy(10, n);
    check("t1_slot_lat", n, 32'd3);
    check("t1_pulses", pulses - p0, 32'd1);
    check("t1_wq_empty", wr_q.size(), 32'd0);
    release_strobes();
    isa_op_enable = 1'b0;

    // Test 2: read B0010 returns 5A.
    rd_q.push_back(8'h5A);
    start_access(1'b0, 20'hB0010, 8'h00);
    cyc();
    check("t2_dir", {31'd0, isa_dir}, 32'd1);
    cyc(); cyc();
    check("t2_rdy_low", {31'd0, isa_rdy}, 32'd0);
    isa_op_enable = 1'b1;
    run_until_rdy(10, n);
    check("t2_dout", {24'd0, isa_dout}, {24'd0, rd_q.pop_front()});
    check("t2_dir_hold", {31'd0, isa_dir}, 32'd1);
    release_strobes();
    check("t2_dir_off", {31'd0, isa_dir}, 32'd0);

    // Test 3: mirrored write, then a read outside the window.
    p0 = pulses;
    wr_q.push_back({19'h00010, 8'hC3});
    start_access(1'b1, 20'hB1010, 8'hC3);
    run_until_rdy(3, n);  // still IDLE before the synchronizer catches up
    repeat (3) cyc();
    run_until_rdy(10, n);
    check("t3_pulses", pulses - p0, 32'd1);
    release_strobes();
    p0 = pulses;
    start_access(1'b0, 20'hA0000, 8'h00);
    cyc();
    check("t3_dir_out", {31'd0, isa_dir}, 32'd0);
    repeat (6) begin
      cyc();
      check("t3_rdy_out", {31'd0, isa_rdy}, 32'd1);
    end
    check("t3_no_sram", pulses - p0, 32'd0);
    release_strobes();

    // Test 4: pixel fetch steals ACC2 of a write; the write finishes in the next slot.
    p0 = pulses;
    wr_q.push_back({19'h00020, 8'h77});
    start_access(1'b1, 20'hB0020, 8'h77);
    repeat (4) cyc();  // WAIT after 3, ACC1 after 4
    pix_addr_next = 19'h12345;
    pix_apply = 1'b1;
    cyc();             // ACC2, pixel_read raised within it
    check("t4_we_l", {31'd0, ram_we_l}, 32'd1);
    check("t4_ram_a", {13'd0, ram_a}, 32'h12345);
    check("t4_no_pulse", pulses - p0, 32'd0);
    cyc();
    check("t4_rdy_abort", {31'd0, isa_rdy}, 32'd0);
    pixel_read = 1'b0;
    run_until_rdy(10, n);
    check("t4_pulses", pulses - p0, 32'd1);
    check("t4_wq_empty", wr_q.size(), 32'd0);
    release_strobes();

    // Test 5: reset in ACC1 aborts at once without a write.
    p0 = pulses;
    start_access(1'b1, 20'hB0030, 8'h99);
    repeat (4) cyc();
    check("t5_in_acc", {31'd0, isa_rdy}, 32'd0);
    reset = 1'b1;
    #1;
    check("t5_rdy", {31'd0, isa_rdy}, 32'd1);
    check("t5_we_l", {31'd0, ram_we_l}, 32'd1);
    check("t5_dout", {24'd0, isa_dout}, 32'd0);
    isa_memw_l = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (6) cyc();
    check("t5_no_write", pulses - p0, 32'd0);
    check("t5_mem", {24'd0, mem[12'h030]}, 32'd0);
    isa_op_enable = 1'b0;

    // Test 6: slot never opens.
    start_access(1'b0, 20'hB0040, 8'h00);
`ifdef VRAM_TIMEOUT_EN
    run_until_rdy(300, n);
    check("t6_to_lat", n, 32'd258);
    check("t6_dout_ff", {24'd0, isa_dout}, 32'h000000FF);
    release_strobes();
`else
    repeat (1000) cyc();
    check("t6_rdy_held", {31'd0, isa_rdy}, 32'd0);
    isa_memr_l = 1'b1;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    check("t6_rdy_reset", {31'd0, isa_rdy}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
